id_scanner: RTL and testbench

Parametrised identifier scanner: consumes one ASCII character per accepted cycle, tracks the current whitespace/punctuation-delimited run, and reports each run as a valid identifier (with its length) or as an error. It is the stream-level successor to the single-bit identifier recogniser. It adds a reset, a valid qualifier, a selectable grammar, length counting with overflow, and a saturating token counter. It sits behind the character source in the lexer front end.

---
 rtl/id_scan_pkg.sv | 28 ++
 rtl/id_char_class.sv | 25 ++
 rtl/id_scanner.sv | 124 ++++++++++++
 tb/tb_id_scanner.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/id_scan_pkg.sv
// Shared types and byte constants for the identifier scanner and the other lexer blocks.
package id_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ALPHA,
    ST_DIGIT,
    ST_BAD
  } state_t;

  typedef enum logic [2:0] {
    CL_LETTER,
    CL_DIGIT,
    CL_UNDER,
    CL_DELIM,
    CL_OTHER
  } cls_t;

  localparam logic [7:0] DELIM_NUL   = 8'h00;
  localparam logic [7:0] DELIM_TAB   = 8'h09;
  localparam logic [7:0] DELIM_LF    = 8'h0A;
  localparam logic [7:0] DELIM_CR    = 8'h0D;
  localparam logic [7:0] DELIM_SP    = 8'h20;
  localparam logic [7:0] DELIM_COMMA = 8'h2C;
  localparam logic [7:0] DELIM_SEMI  = 8'h3B;
  localparam logic [7:0] CHAR_UNDER  = 8'h5F;

endpackage

// File: rtl/id_char_class.sv
// Combinational ASCII character classifier; in the legacy grammar underscore is just OTHER.
module id_char_class
  import id_scan_pkg::*;
#(
  parameter int MODE = 0
) (
  input  logic [7:0] char,
  output cls_t       cls
);

  always_comb begin
    cls = CL_OTHER;
    if ((char >= 8'h41 && char <= 8'h5A) || (char >= 8'h61 && char <= 8'h7A))
      cls = CL_LETTER;
    else if (char >= 8'h30 && char <= 8'h39)
      cls = CL_DIGIT;
    else if (char == CHAR_UNDER && MODE == 0)
      cls = CL_UNDER;
    else if (char == DELIM_NUL || char == DELIM_TAB || char == DELIM_LF ||
             char == DELIM_CR  || char == DELIM_SP  || char == DELIM_COMMA ||
             char == DELIM_SEMI)
      cls = CL_DELIM;
  end

endmodule

// File: rtl/id_scanner.sv
// Stream identifier scanner: classifies delimiter-separated runs, reports length,
// overflow and a saturating count of accepted tokens. All outputs registered.
//
// state    | meaning
// ST_IDLE  | at a token boundary, no run in progress
// ST_ALPHA | run so far is letters (plus digits/underscore in MODE 0)
// ST_DIGIT | MODE 1 only: letters followed by at least one digit
// ST_BAD   | run can no longer be a legal identifier (or overflowed)
module id_scanner
  import id_scan_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int MODE    = 0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       char,
  input  logic             char_valid,
  output logic             out,
  output logic             tok_done,
  output logic [LEN_W-1:0] tok_len,
  output logic             tok_err,
  output logic             tok_ovf,
  output logic [CNT_W-1:0] tok_count
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  cls_t             cls;
  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;
  logic             out_d, done_d, err_d, tovf_d;
  logic [LEN_W-1:0] tlen_d;

  id_char_class #(.MODE(MODE)) u_class (
    .char (char),
    .cls  (cls)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      ovf_q     <= 1'b0;
      out       <= 1'b0;
      tok_done  <= 1'b0;
      tok_err   <= 1'b0;
      tok_ovf   <= 1'b0;
      tok_len   <= '0;
      tok_count <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      ovf_q    <= ovf_d;
      out      <= out_d;
      tok_done <= done_d;
      tok_err  <= err_d;
      tok_ovf  <= tovf_d;
      tok_len  <= tlen_d;
      if (done_d && tok_count != {CNT_W{1'b1}})
        tok_count <= tok_count + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    tovf_d  = 1'b0;
    tlen_d  = tok_len;

    if (char_valid) begin
      if (cls == CL_DELIM) begin
        state_d = ST_IDLE;
        len_d   = '0;
        ovf_d   = 1'b0;
        if (state_q != ST_IDLE)
          tlen_d = len_q;
        unique case (state_q)
          ST_ALPHA: begin
            if (MODE == 0) done_d = 1'b1;
            else           err_d  = 1'b1;
          end
          ST_DIGIT: done_d = 1'b1;
          ST_BAD: begin
            err_d  = 1'b1;
            tovf_d = ovf_q;
          end
          default: ;
        endcase
      end else if (state_q != ST_IDLE && len_q == LEN_MAX) begin
        // Too long: length pins at MAX_LEN and the run is condemned.
        state_d = ST_BAD;
        ovf_d   = 1'b1;
      end else begin
        len_d = len_q + LEN_W'(1);
        unique case (state_q)
          ST_IDLE:
            state_d = (cls == CL_LETTER || cls == CL_UNDER) ? ST_ALPHA : ST_BAD;
          ST_ALPHA: begin
            if (cls == CL_LETTER || (MODE == 0 && (cls == CL_DIGIT || cls == CL_UNDER)))
              state_d = ST_ALPHA;
            else if (MODE != 0 && cls == CL_DIGIT)
              state_d = ST_DIGIT;
            else
              state_d = ST_BAD;
          end
          ST_DIGIT:
            state_d = (cls == CL_DIGIT) ? ST_DIGIT : ST_BAD;
          default:
            state_d = ST_BAD;
        endcase
      end
    end

    out_d = (MODE == 0) ? (state_d == ST_ALPHA) : (state_d == ST_DIGIT);
  end

endmodule

// File: tb/tb_id_scanner.sv
// Table-driven bench for id_scanner across four parameter sets, with a scoreboard queue.
module tb_id_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ch = 8'h20;
  logic [3:0] vld = '0;

  logic       o0, d0, e0, v0, o1, d1, e1, v1, o2, d2, e2, v2, o3, d3, e3, v3;
  logic [4:0] l0, l1, l3;
  logic [2:0] l2;
  logic [15:0] c0, c1, c2;
  logic [1:0]  c3;

  always #5 clk = ~clk;

  id_scanner u0 (.clk(clk), .rst_n(rst_n), .char(ch), .char_valid(vld[0]), .out(o0),
                 .tok_done(d0), .tok_len(l0), .tok_err(e0), .tok_ovf(v0), .tok_count(c0));
  id_scanner #(.MODE(1)) u1 (.clk(clk), .rst_n(rst_n), .char(ch), .char_valid(vld[1]), .out(o1),
                 .tok_done(d1), .tok_len(l1), .tok_err(e1), .tok_ovf(v1), .tok_count(c1));
  id_scanner #(.MAX_LEN(4)) u2 (.clk(clk), .rst_n(rst_n), .char(ch), .char_valid(vld[2]), .out(o2),
                 .tok_done(d2), .tok_len(l2), .tok_err(e2), .tok_ovf(v2), .tok_count(c2));
  id_scanner #(.CNT_W(2)) u3 (.clk(clk), .rst_n(rst_n), .char(ch), .char_valid(vld[3]), .out(o3),
                 .tok_done(d3), .tok_len(l3), .tok_err(e3), .tok_ovf(v3), .tok_count(c3));

  typedef struct {
    int         sel;
    logic [7:0] c;
    logic       v;
    logic       o, d, e, ov;
    int         len;   // -1: not checked
    int         cnt;   // -1: not checked
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   a_o, a_d, a_e, a_v, a_l, a_c;

  task automatic add(input int sel, input logic [7:0] c, input logic v, input logic o,
                     input logic d, input logic e, input logic ov, input int len, input int cnt);
    vec_t t;
    t.sel = sel; t.c = c; t.v = v; t.o = o; t.d = d; t.e = e; t.ov = ov;
    t.len = len; t.cnt = cnt;
    vecs.push_back(t);
  endtask

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", n, act, exp);
    end
  endtask

  task automatic sample(input int sel);
    case (sel)
      0: begin a_o = o0; a_d = d0; a_e = e0; a_v = v0; a_l = l0; a_c = c0; end
      1: begin a_o = o1; a_d = d1; a_e = e1; a_v = v1; a_l = l1; a_c = c1; end
      2: begin a_o = o2; a_d = d2; a_e = e2; a_v = v2; a_l = l2; a_c = c2; end
      default: begin a_o = o3; a_d = d3; a_e = e3; a_v = v3; a_l = l3; a_c = c3; end
    endcase
  endtask

  task automatic chk_all(input string tag, input int sel, input vec_t e);
    sample(sel);
    chk({tag, "_out"}, a_o, int'(e.o));
    chk({tag, "_done"}, a_d, int'(e.d));
    chk({tag, "_err"}, a_e, int'(e.e));
    chk({tag, "_ovf"}, a_v, int'(e.ov));
    if (e.len >= 0) chk({tag, "_len"}, a_l, e.len);
    if (e.cnt >= 0) chk({tag, "_cnt"}, a_c, e.cnt);
  endtask

  initial begin
    vec_t e;
    // MODE 0
    add(0, "a", 1, 1, 0, 0, 0, -1, 0);
    add(0, "b", 1, 1, 0, 0, 0, -1, -1);
    add(0, "c", 1, 1, 0, 0, 0, -1, -1);
    add(0, "1", 1, 1, 0, 0, 0, -1, -1);
    add(0, " ", 1, 0, 1, 0, 0, 4, 1);
    add(0, "1", 1, 0, 0, 0, 0, -1, -1);
    add(0, "a", 1, 0, 0, 0, 0, -1, -1);
    add(0, "b", 1, 0, 0, 0, 0, -1, -1);
    add(0, ";", 1, 0, 0, 1, 0, 3, 1);
    add(0, "_", 1, 1, 0, 0, 0, -1, -1);
    add(0, "x", 1, 1, 0, 0, 0, -1, -1);
    add(0, "9", 1, 1, 0, 0, 0, -1, -1);
    add(0, ",", 1, 0, 1, 0, 0, 3, 2);
    add(0, "a", 1, 1, 0, 0, 0, -1, -1);
    add(0, "b", 1, 1, 0, 0, 0, -1, -1);
    add(0, "z", 0, 1, 0, 0, 0, -1, 2);
    add(0, " ", 0, 1, 0, 0, 0, -1, 2);
    add(0, "!", 0, 1, 0, 0, 0, -1, 2);
    add(0, "c", 1, 1, 0, 0, 0, -1, -1);
    add(0, 8'h09, 1, 0, 1, 0, 0, 3, 3);
    add(0, " ", 1, 0, 0, 0, 0, -1, 3);
    add(0, "a", 1, 1, 0, 0, 0, -1, -1);
    add(0, "-", 1, 0, 0, 0, 0, -1, -1);
    add(0, 8'h00, 1, 0, 0, 1, 0, 2, 3);
    // MODE 1
    add(1, "a", 1, 0, 0, 0, 0, -1, -1);
    add(1, "b", 1, 0, 0, 0, 0, -1, -1);
    add(1, "c", 1, 0, 0, 0, 0, -1, -1);
    add(1, "d", 1, 0, 0, 0, 0, -1, -1);
    add(1, "1", 1, 1, 0, 0, 0, -1, -1);
    add(1, "2", 1, 1, 0, 0, 0, -1, -1);
    add(1, "3", 1, 1, 0, 0, 0, -1, -1);
    add(1, "4", 1, 1, 0, 0, 0, -1, -1);
    add(1, " ", 1, 0, 1, 0, 0, 8, 1);
    add(1, "a", 1, 0, 0, 0, 0, -1, -1);
    add(1, "b", 1, 0, 0, 0, 0, -1, -1);
    add(1, " ", 1, 0, 0, 1, 0, 2, 1);
    add(1, "a", 1, 0, 0, 0, 0, -1, -1);
    add(1, "1", 1, 1, 0, 0, 0, -1, -1);
    add(1, "b", 1, 0, 0, 0, 0, -1, -1);
    add(1, " ", 1, 0, 0, 1, 0, 3, 1);
    add(1, "a", 1, 0, 0, 0, 0, -1, -1);
    add(1, "_", 1, 0, 0, 0, 0, -1, -1);
    add(1, "1", 1, 0, 0, 0, 0, -1, -1);
    add(1, 8'h0A, 1, 0, 0, 1, 0, 3, 1);
    // MAX_LEN = 4
    add(2, "a", 1, 1, 0, 0, 0, -1, -1);
    add(2, "b", 1, 1, 0, 0, 0, -1, -1);
    add(2, "c", 1, 1, 0, 0, 0, -1, -1);
    add(2, "d", 1, 1, 0, 0, 0, -1, -1);
    add(2, "e", 1, 0, 0, 0, 0, -1, -1);
    add(2, " ", 1, 0, 0, 1, 1, 4, 0);
    add(2, "a", 1, 1, 0, 0, 0, -1, -1);
    add(2, "b", 1, 1, 0, 0, 0, -1, -1);
    add(2, " ", 1, 0, 1, 0, 0, 2, 1);
    add(2, "a", 1, 1, 0, 0, 0, -1, -1);
    add(2, "b", 1, 1, 0, 0, 0, -1, -1);
    add(2, "c", 1, 1, 0, 0, 0, -1, -1);
    add(2, "d", 1, 1, 0, 0, 0, -1, -1);
    add(2, 8'h0D, 1, 0, 1, 0, 0, 4, 2);
    // CNT_W = 2 saturation
    for (int k = 0; k < 5; k++) begin
      add(3, "a", 1, 1, 0, 0, 0, -1, -1);
      add(3, " ", 1, 0, 1, 0, 0, 1, (k < 3) ? k + 1 : 3);
      add(3, " ", 1, 0, 0, 0, 0, -1, (k < 3) ? k + 1 : 3);
    end

    // reset state
    repeat (2) @(posedge clk);
    #1;
    e.o = 0; e.d = 0; e.e = 0; e.ov = 0; e.len = 0; e.cnt = 0;
    for (int s = 0; s < 4; s++) chk_all($sformatf("rst_u%0d", s), s, e);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      ch  = vecs[i].c;
      vld = '0;
      if (vecs[i].v) vld[vecs[i].sel] = 1'b1;
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk_all($sformatf("v%0d", i), e.sel, e);
    end

    // reset mid-run on u0
    @(negedge clk); ch = "x"; vld = 4'b0001;
    @(negedge clk); ch = "y";
    @(posedge clk); #1;
    sample(0);
    chk("midrun_out_pre", a_o, 1);
    #2 rst_n = 1'b0;
    #1;
    e.o = 0; e.d = 0; e.e = 0; e.ov = 0; e.len = 0; e.cnt = 0;
    chk_all("midrun_rst", 0, e);
    @(negedge clk); ch = " "; rst_n = 1'b1;
    @(posedge clk); #1;
    e.len = -1;
    chk_all("post_rst_delim", 0, e);
    @(negedge clk); ch = "q";
    @(negedge clk); ch = ",";
    @(posedge clk); #1;
    e.d = 1; e.len = 1; e.cnt = 1;
    chk_all("post_rst_tok", 0, e);
    @(negedge clk); vld = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
